// File: rtl/pressure_frame_receiver.sv
// pressure_frame_receiver
// Serial-to-parallel receiver for the pressure sensor link. It waits for a start
// bit on the idle-high line, then samples FRAME_BITS bits LSB first at mid-bit
// (payload plus parity, passed through unchecked). It checks the stop bit and
// presents the word with a one-cycle frameValid strobe, or raises a one-cycle
// framingError strobe.
// Optional feature macro: PRESSURE_RX_ERRCNT_EN builds a saturating framing-error
// counter on errCount. Without it, errCount is tied to zero.
module pressure_frame_receiver #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FRAME_BITS   = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  serialIn,
    output logic [FRAME_BITS-1:0] frameData,
    output logic                  frameValid,
    output logic                  framingError,
    output logic                  busy,
    output logic [7:0]            errCount
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_sync3;
    logic                  r_fall;
    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [FRAME_BITS-1:0] r_shift;
    logic [FRAME_BITS-1:0] r_data;
    logic                  r_valid;
    logic                  r_ferr;

    state_t                w_state_next;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [IDX_W-1:0]      w_idx_next;
    logic [FRAME_BITS-1:0] w_shift_next;
    logic [FRAME_BITS-1:0] w_data_next;
    logic                  w_valid_next;
    logic                  w_ferr_next;

    // Two-flop synchronizer, a delay flop for edge detection, and a registered
    // falling-edge pulse. The flops reset to 1 so that reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
            r_fall  <= 1'b0;
        end else begin
            r_sync1 <= serialIn;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_fall  <= r_sync3 & ~r_sync2;
        end
    end

    // Frame FSM next-state logic. The counters alone decide when to sample.
    // Falling edges are only honoured in IDLE.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 1'b1;
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_data_next  = r_data;
        w_valid_next = 1'b0;
        w_ferr_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (r_fall) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (r_cnt == CNT_HALF) begin
                    w_cnt_next = '0;
                    if (!r_sync2) begin
                        w_state_next = S_DATA;
                        w_idx_next   = '0;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (r_cnt == CNT_FULL) begin
                    w_cnt_next          = '0;
                    w_shift_next[r_idx] = r_sync2;
                    if (r_idx == IDX_LAST) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (r_cnt == CNT_FULL) begin
                    w_cnt_next = '0;
                    if (r_sync2) begin
                        w_data_next  = r_shift;
                        w_valid_next = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_ferr_next  = 1'b1;
                        w_state_next = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                // A line held low after a bad stop bit raises only the one error.
                w_cnt_next = '0;
                if (r_sync2) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // FSM state, counters, shift register, output word and strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_shift <= w_shift_next;
            r_data  <= w_data_next;
            r_valid <= w_valid_next;
            r_ferr  <= w_ferr_next;
        end
    end

    assign frameData    = r_data;
    assign frameValid   = r_valid;
    assign framingError = r_ferr;
    assign busy         = (r_state != S_IDLE);

`ifdef PRESSURE_RX_ERRCNT_EN
    logic [7:0] r_errcnt;

    // Saturating framing-error counter. It steps together with the error strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_errcnt <= 8'h00;
        end else if (w_ferr_next && (r_errcnt != 8'hFF)) begin
            r_errcnt <= r_errcnt + 8'd1;
        end
    end

    assign errCount = r_errcnt;
`else
    assign errCount = 8'h00;
`endif

endmodule

// File: tb/tb_pressure_frame_receiver.sv
// Testbench for pressure_frame_receiver: a stimulus process serialises frames onto
// the line and queues the expected strobe (kind, data, arrival cycle). A monitor
// pops and checks the queue whenever a strobe appears.
module tb_pressure_frame_receiver;

    localparam int CPB     = 16;
    localparam int NBITS   = 6;
    localparam int LATENCY = 3 + CPB / 2 + (NBITS + 1) * CPB + 1;

    logic       clk;
    logic       rst_n;
    logic       serialIn;
    logic [5:0] frameData;
    logic       frameValid;
    logic       framingError;
    logic       busy;
    logic [7:0] errCount;

    typedef struct {
        bit          is_err;
        logic [5:0]  data;
        int unsigned cyc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    logic [5:0]  m_last = 6'h00;
    int          m_err = 0;
    logic        prev_busy = 1'b0;
    int          exp_ec;

    pressure_frame_receiver #(.CLKS_PER_BIT(CPB), .FRAME_BITS(NBITS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .serialIn     (serialIn),
        .frameData    (frameData),
        .frameValid   (frameValid),
        .framingError (framingError),
        .busy         (busy),
        .errCount     (errCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_last    = 6'h00;
            m_err     = 0;
            prev_busy = 1'b0;
        end else begin
            if (frameValid && framingError) begin
                checks++; errors++;
                $display("FAIL both_strobes: valid=%0b ferr=%0b at cycle %0d", frameValid, framingError, cyc);
            end
            if (frameValid || framingError) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_strobe: valid=%0b ferr=%0b data=%0h at cycle %0d, none expected",
                             frameValid, framingError, frameData, cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    checks++;
                    if (framingError != mon_e.is_err) begin
                        errors++;
                        $display("FAIL strobe_kind: ferr=%0b expected %0b", framingError, mon_e.is_err);
                    end
                    checks++;
                    if (cyc != mon_e.cyc) begin
                        errors++;
                        $display("FAIL latency: strobe at cycle %0d expected %0d", cyc, mon_e.cyc);
                    end
                    if (!mon_e.is_err) begin
                        m_last = mon_e.data;
                        checks++;
                        if (frameData !== mon_e.data) begin
                            errors++;
                            $display("FAIL frame_data: got %0h expected %0h", frameData, mon_e.data);
                        end
                        checks++;
                        if (busy !== 1'b0 || prev_busy !== 1'b1) begin
                            errors++;
                            $display("FAIL busy_fall: busy=%0b prev=%0b expected 0 after 1", busy, prev_busy);
                        end
                    end else begin
                        if (m_err < 255) m_err++;
                        checks++;
                        if (frameData !== m_last) begin
                            errors++;
                            $display("FAIL data_hold_on_error: got %0h expected %0h", frameData, m_last);
                        end
                    end
`ifdef PRESSURE_RX_ERRCNT_EN
                    exp_ec = m_err;
`else
                    exp_ec = 0;
`endif
                    checks++;
                    if (errCount !== 8'(exp_ec)) begin
                        errors++;
                        $display("FAIL err_count: got %0d expected %0d", errCount, exp_ec);
                    end
                end
            end
            prev_busy = busy;
        end
    end

    // Drive one frame: start bit, 6 bits LSB first, stop bit, an optional low hold, then an idle gap.
    task automatic send_frame(input logic [5:0] d, input bit stop, input int low_after, input int gap);
        exp_t e;
        e.is_err = !stop;
        e.data   = d;
        e.cyc    = cyc + LATENCY;
        sb_q.push_back(e);
        serialIn = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < NBITS; i++) begin
            serialIn = d[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        serialIn = stop;
        repeat (CPB) @(posedge clk);
        #1;
        if (low_after > 0) begin
            serialIn = 1'b0;
            repeat (low_after) @(posedge clk);
            #1;
        end
        serialIn = 1'b1;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    // Short low pulse that must be rejected; afterwards the receiver must be idle with data unchanged.
    task automatic glitch(input int len);
        serialIn = 1'b0;
        repeat (len) @(posedge clk);
        #1;
        serialIn = 1'b1;
        repeat (24) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || frameData !== m_last) begin
            errors++;
            $display("FAIL glitch_reject: busy=%0b data=%0h expected busy 0 data %0h", busy, frameData, m_last);
        end
    endtask

    initial begin
        int bad;
        logic [5:0] rd;
        bit st;
        serialIn = 1'b1;
        rst_n    = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle line after reset: all outputs must stay 0 for 200 cycles.
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (frameData !== 6'h00 || frameValid !== 1'b0 || framingError !== 1'b0 ||
                busy !== 1'b0 || errCount !== 8'h00) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_idle: %0d nonzero cycles, expected 0", bad);
        end
        @(posedge clk);
        #1;

        // Directed frames from the plan.
        send_frame(6'h2D, 1'b1, 0, 20);
        glitch(5);
        send_frame(6'h15, 1'b0, 100, 20);
        send_frame(6'h3F, 1'b1, 0, 20);
        send_frame(6'h01, 1'b1, 0, 0);
        send_frame(6'h3E, 1'b1, 0, 20);

        // Reset in the middle of bit 3: the partial frame must vanish.
        serialIn = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            serialIn = i[0];
            repeat (CPB) @(posedge clk);
            #1;
        end
        serialIn = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (frameData !== 6'h00 || busy !== 1'b0 || frameValid !== 1'b0 || errCount !== 8'h00) begin
            errors++;
            $display("FAIL mid_frame_reset: data=%0h busy=%0b valid=%0b ec=%0d expected all 0",
                     frameData, busy, frameValid, errCount);
        end
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        send_frame(6'h2A, 1'b1, 0, 20);

        // Random frames, stop errors, back-to-back gaps and glitches.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                glitch(int'($urandom_range(1, 6)));
            end else begin
                rd = 6'($urandom);
                st = ($urandom_range(0, 4) != 0);
                if (st) send_frame(rd, 1'b1, 0, int'($urandom_range(0, 11)));
                else    send_frame(rd, 1'b0, 0, 8 + int'($urandom_range(0, 9)));
            end
        end

        // Drive the error counter well past saturation.
        for (int n = 0; n < 300; n++) begin
            send_frame(6'($urandom), 1'b0, 0, 8);
        end

        repeat (50) @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL missing_strobes: %0d expected strobes never seen, expected 0", sb_q.size());
        end
        checks++;
`ifdef PRESSURE_RX_ERRCNT_EN
        if (errCount !== 8'hFF) begin
            errors++;
            $display("FAIL err_saturate: got %0h expected ff", errCount);
        end
`else
        if (errCount !== 8'h00) begin
            errors++;
            $display("FAIL err_tied_zero: got %0h expected 0", errCount);
        end
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
